// File: rtl/sp_ram_pkg.sv
// Shared types, mode constants and byte-merge helper for the single-port RAM controller.
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Read-during-write result selection
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_W = 1024;

    // Replace each byte of old_word whose enable bit is set with the matching byte of new_word.
    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]   old_word,
        input logic [MAX_W-1:0]   new_word,
        input logic [MAX_W/8-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_W / 8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Pure storage: one byte-wide bank per lane, synchronous masked write, registered read-first output.
module sp_ram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            // Per-lane bank: read returns the pre-write contents, write honours this lane's enable
            always_ff @(posedge clk) begin
                if (en) begin
                    lane_rd_reg <= lane_mem[addr];
                    if (we && be[gi]) begin
                        lane_mem[addr] <= wdata[8*gi +: 8];
                    end
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: post-reset zero sweep, request handshake, range check,
// read-during-write mode selection and optional output pipeline register.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  write_en,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     Data_in,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     Data_out,
    output logic                  addr_err,
    output logic                  init_done
);

    localparam int                NBYTES    = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                accept, in_range;

    logic                mem_en, mem_we;
    logic [NBYTES-1:0]   mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;

    logic                s1_valid_reg, s1_write_reg, s1_err_reg;
    logic [DATA_W-1:0]   s1_wdata_reg;
    logic [NBYTES-1:0]   s1_be_reg;

    logic                resp_rd, resp_err;
    logic [DATA_W-1:0]   resp_data, merged;

    // State and sweep counter; reset restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next state: sweep one word per cycle, leave CLEAR after the last word
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign accept   = req_valid && req_ready && rst_n;
    assign in_range = ({1'b0, addr} < DEPTH_C);

    // Array port mux: sweep owns the port in CLEAR; out-of-range requests never touch it
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = addr;
        mem_wdata = Data_in;
        if (state_reg == ST_CLEAR && rst_n) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = clr_cnt_reg;
            mem_wdata = '0;
        end else if (accept && in_range) begin
            mem_en = 1'b1;
            mem_we = write_en;
            mem_be = byte_en;
        end
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Request attributes travel alongside the array read so the response can be formed next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_write_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s1_write_reg <= write_en;
            s1_err_reg   <= !in_range;
        end
        s1_wdata_reg <= Data_in;
        s1_be_reg    <= byte_en;
    end

    // Response: out-of-range reads as zero, writes report the merged word only in write-first mode
    always_comb begin
        merged   = (DATA_W)'(merge_bytes((MAX_W)'(mem_rdata), (MAX_W)'(s1_wdata_reg),
                                         (MAX_W / 8)'(s1_be_reg)));
        resp_rd  = s1_valid_reg && (!s1_write_reg || RD_MODE == WR_FIRST);
        resp_err = s1_valid_reg && s1_err_reg;
        if (s1_err_reg) begin
            resp_data = '0;
        end else if (s1_write_reg) begin
            resp_data = merged;
        end else begin
            resp_data = mem_rdata;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                rd_valid_reg, addr_err_reg;
            logic [DATA_W-1:0]   data_out_reg;

            // Extra pipeline stage; data register only loads on a response so it holds between reads
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_valid_reg <= 1'b0;
                    addr_err_reg <= 1'b0;
                    data_out_reg <= '0;
                end else begin
                    rd_valid_reg <= resp_rd;
                    addr_err_reg <= resp_err;
                    if (resp_rd) begin
                        data_out_reg <= resp_data;
                    end
                end
            end

            assign rd_valid = rd_valid_reg;
            assign addr_err = addr_err_reg;
            assign Data_out = data_out_reg;
        end else begin : g_out_direct
            logic [DATA_W-1:0] hold_reg;

            // Remember the last presented word so Data_out holds while the array port is reused
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else begin
                    hold_reg <= Data_out;
                end
            end

            assign rd_valid = resp_rd;
            assign addr_err = resp_err;
            assign Data_out = resp_rd ? resp_data : hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench: two controller instances (32 words read-first direct output,
// 24 words write-first registered output) driven by the same request stream.
module tb_sp_ram_ctrl;

    typedef struct packed {
        int          due;
        logic        rv;
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        write_en;
    logic [1:0]  byte_en;
    logic [4:0]  addr;
    logic [15:0] data_in;

    logic        ready_w [2];
    logic        rdv_w   [2];
    logic        err_w   [2];
    logic        init_w  [2];
    logic [15:0] dout_w  [2];

    int          cyc = 0;
    bit          rst_seen = 1'b0;
    bit          mon_en = 1'b0;
    int          sweep_left [2];
    logic [15:0] mdl_mem [2][32];
    logic [15:0] last_data [2];
    exp_t        exp_q [2][$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sp_ram_ctrl #(.DATA_W(16), .DEPTH(32), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[0]),
        .write_en(write_en), .byte_en(byte_en), .addr(addr), .Data_in(data_in),
        .rd_valid(rdv_w[0]), .Data_out(dout_w[0]), .addr_err(err_w[0]), .init_done(init_w[0])
    );

    sp_ram_ctrl #(.DATA_W(16), .DEPTH(24), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[1]),
        .write_en(write_en), .byte_en(byte_en), .addr(addr), .Data_in(data_in),
        .rd_valid(rdv_w[1]), .Data_out(dout_w[1]), .addr_err(err_w[1]), .init_done(init_w[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit wr_first(input int k);
        return (k == 1);
    endfunction

    function automatic int extra_lat(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle counter and expected sweep countdown (requests are refused until it reaches zero)
    always @(posedge clk) begin
        cyc++;
        rst_seen = !rst_n;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) sweep_left[k] = dep(k);
            else if (sweep_left[k] > 0) sweep_left[k]--;
        end
    end

    // Reference model: behavioural memory, result pushed with the cycle it must appear
    task automatic model_apply(input int k, input bit we, input logic [1:0] be,
                               input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        e.due  = cyc + 1 + extra_lat(k);
        e.err  = (int'(a) >= dep(k));
        e.rv   = 1'b1;
        e.data = 16'h0000;
        if (e.err) begin
            if (we) e.rv = wr_first(k);
            exp_q[k].push_back(e);
        end else if (we) begin
            for (int i = 0; i < 2; i++)
                if (be[i]) mdl_mem[k][a][8*i +: 8] = d[8*i +: 8];
            if (wr_first(k)) begin
                e.data = mdl_mem[k][a];
                exp_q[k].push_back(e);
            end
        end else begin
            e.data = mdl_mem[k][a];
            exp_q[k].push_back(e);
        end
    endtask

    // Monitor: compares every cycle; pops an expectation when one falls due
    task automatic monitor_inst(input int k);
        exp_t e;
        if (rst_seen) begin
            check($sformatf("rst_outputs[%0d]", k),
                  {13'd0, rdv_w[k], err_w[k], ready_w[k], dout_w[k]}, 32'd0);
            last_data[k] = 16'h0000;
            return;
        end
        check($sformatf("req_ready[%0d]", k), 32'(ready_w[k]), 32'(sweep_left[k] == 0));
        check($sformatf("init_done[%0d]", k), 32'(init_w[k]), 32'(sweep_left[k] == 0));
        if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
            e = exp_q[k].pop_front();
            check($sformatf("due_cycle[%0d]", k), 32'(cyc), 32'(e.due));
            check($sformatf("rd_valid[%0d]", k), 32'(rdv_w[k]), 32'(e.rv));
            check($sformatf("addr_err[%0d]", k), 32'(err_w[k]), 32'(e.err));
            if (e.rv) last_data[k] = e.data;
            check($sformatf("Data_out[%0d]", k), 32'(dout_w[k]), 32'(last_data[k]));
            $display("inst %0d cyc %0d: rd_valid=%0b addr_err=%0b Data_out=0x%04h", k, cyc,
                     rdv_w[k], err_w[k], dout_w[k]);
        end else begin
            check($sformatf("idle_pulses[%0d]", k), {30'd0, rdv_w[k], err_w[k]}, 32'd0);
            check($sformatf("Data_out_hold[%0d]", k), 32'(dout_w[k]), 32'(last_data[k]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) monitor_inst(k);
            end
        end
    end

    task automatic issue(input bit v, input bit we, input logic [1:0] be,
                         input logic [4:0] a, input logic [15:0] d);
        req_valid = v;
        write_en  = we;
        byte_en   = be;
        addr      = a;
        data_in   = d;
        if (v) begin
            for (int k = 0; k < 2; k++)
                if (sweep_left[k] == 0) model_apply(k, we, be, a, d);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic random_req(input int valid_pct);
        issue(($urandom_range(0, 99) < valid_pct), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom));
    endtask

    // Reset: drop expectations the reset edge will cancel; the sweep re-zeros the array
    task automatic do_reset(input int n_low);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            while (exp_q[k].size() > 0 && exp_q[k][exp_q[k].size() - 1].due > cyc)
                void'(exp_q[k].pop_back());
            for (int a = 0; a < 32; a++) mdl_mem[k][a] = 16'h0000;
        end
        repeat (n_low) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; write_en = 1'b0;
        byte_en = 2'b00; addr = 5'd0; data_in = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            sweep_left[k] = dep(k);
            last_data[k]  = 16'h0000;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset(1);

        // Requests during the sweep must be ignored
        for (int i = 0; i < 34; i++) random_req(80);

        // Whole address range reads back zero (out-of-range on the 24-word instance)
        for (int a = 0; a < 32; a++) issue(1, 0, 2'b00, 5'(a), 16'h0000);

        // Partial byte write merges into the previous word
        issue(1, 1, 2'b11, 5'd5, 16'hBEEF);
        issue(1, 1, 2'b10, 5'd5, 16'h12AB);
        issue(1, 0, 2'b00, 5'd5, 16'h0000);
        issue(1, 1, 2'b11, 5'd3, 16'hA5A5);
        issue(0, 0, 2'b00, 5'd0, 16'h0000);
        issue(1, 1, 2'b00, 5'd3, 16'h5A5A);
        issue(1, 0, 2'b00, 5'd3, 16'h0000);

        // Out-of-range write dropped, read of the same address returns zero
        issue(1, 1, 2'b11, 5'd30, 16'hFFFF);
        issue(1, 0, 2'b00, 5'd30, 16'h0000);
        for (int a = 0; a < 32; a++) issue(1, 0, 2'b00, 5'(a), 16'h0000);

        // Back-to-back writes then reads
        for (int a = 0; a < 8; a++) issue(1, 1, 2'b11, 5'(a), 16'(a * 16'h1111));
        for (int a = 0; a < 8; a++) issue(1, 0, 2'b00, 5'(a), 16'h0000);

        for (int i = 0; i < 200; i++) random_req(75);
        repeat (3) issue(0, 0, 2'b00, 5'd0, 16'h0000);

        // Reset one cycle at sweep count 10: sweep must restart and run full length
        do_reset(2);
        repeat (10) issue(0, 0, 2'b00, 5'd0, 16'h0000);
        do_reset(1);
        for (int i = 0; i < 34; i++) random_req(50);
        for (int a = 0; a < 32; a++) issue(1, 0, 2'b00, 5'(a), 16'h0000);

        // Reset while a registered-output read is still in flight
        issue(1, 1, 2'b11, 5'd9, 16'h1234);
        issue(1, 0, 2'b00, 5'd9, 16'h0000);
        do_reset(1);
        repeat (34) issue(0, 0, 2'b00, 5'd0, 16'h0000);
        for (int i = 0; i < 40; i++) random_req(90);

        repeat (4) issue(0, 0, 2'b00, 5'd0, 16'h0000);
        for (int k = 0; k < 2; k++)
            check($sformatf("pending_left[%0d]", k), 32'(exp_q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
